// File: rtl/fifo_stream_pkg.sv
// Shared types and sizing helpers for the FIFO read-side streaming path.
package fifo_stream_pkg;

    localparam int SKID_DEPTH      = 2;
    localparam int BEAT_DATA_WIDTH = 64;

    typedef struct packed {
        logic [BEAT_DATA_WIDTH-1:0] data;
        logic                       last;
    } stream_beat_t;

    // Index width for a counter over n values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry skid buffer; the head entry drives the stream, the tail absorbs
// the word already in flight from the FIFO when the consumer stalls.
module stream_skid2
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid,
    output logic [1:0]            occ
);

    localparam logic [1:0] OCC_FULL = 2'(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] head_r;
    logic [DATA_WIDTH-1:0] tail_r;
    logic [1:0]            occ_r;
    logic                  valid_r;
    logic                  pop_s;

    assign pop_s      = pop && valid_r;
    assign head_data  = head_r;
    assign head_valid = valid_r;
    assign occ        = occ_r;

    // Entry storage and occupancy; clear wins over a concurrent push so a
    // word landing on the flush edge is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {DATA_WIDTH{1'b0}};
            tail_r  <= {DATA_WIDTH{1'b0}};
            occ_r   <= 2'd0;
            valid_r <= 1'b0;
        end else if (clear) begin
            occ_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            case ({push, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        head_r  <= push_data;
                        occ_r   <= 2'd1;
                        valid_r <= 1'b1;
                    end else if (occ_r == 2'd1) begin
                        tail_r <= push_data;
                        occ_r  <= OCC_FULL;
                    end else begin
                        occ_r <= occ_r;
                    end
                end
                2'b01: begin
                    head_r  <= tail_r;
                    occ_r   <= occ_r - 2'd1;
                    valid_r <= (occ_r == OCC_FULL);
                end
                2'b11: begin
                    if (occ_r == OCC_FULL) begin
                        head_r <= tail_r;
                        tail_r <= push_data;
                    end else begin
                        head_r <= push_data;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/stream_skid2_chk.sv
// Simulation checker for the skid buffer: occupancy stays within depth and a
// push never lands on a full buffer without a matching pop.
module stream_skid2_chk
    import fifo_stream_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    input logic       push,
    input logic       pop,
    input logic       head_valid,
    input logic [1:0] occ
);

    // Sampled on every active edge outside reset.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (occ <= 2'(SKID_DEPTH));
            assert (!(push && !(pop && head_valid) && (occ == 2'(SKID_DEPTH))));
        end
    end

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side FIFO consumer: issues rdreq, absorbs the registered read latency
// in a 2-entry skid and presents a framed valid/ready stream with statistics.
module fifo_rd_streamer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int PKT_BEATS  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  rdclk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    input  logic                  fifo_rdempty,
    output logic                  fifo_rdreq,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    localparam int                   IDX_W    = clog2_min1(PKT_BEATS);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(PKT_BEATS - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);

    logic                 inflight_r;
    logic [IDX_W-1:0]     idx_r;
    logic [CNT_WIDTH-1:0] beat_cnt_r;
    logic [CNT_WIDTH-1:0] pkt_cnt_r;
    logic [1:0]           occ_s;
    logic                 head_valid_s;
    logic                 pop_s;
    logic                 last_s;
    logic [2:0]           load_s;
    logic                 rdreq_s;

    stream_skid2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (rdclk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (inflight_r),
        .push_data (fifo_q),
        .pop       (pop_s),
        .head_data (m_data),
        .head_valid(head_valid_s),
        .occ       (occ_s)
    );

    assign pop_s      = head_valid_s && m_ready;
    assign last_s     = head_valid_s && (idx_r == IDX_LAST);
    assign m_valid    = head_valid_s;
    assign m_last     = last_s;
    assign fifo_rdreq = rdreq_s;
    assign beat_cnt   = beat_cnt_r;
    assign pkt_cnt    = pkt_cnt_r;

    // Request only when a skid slot is guaranteed free on the capture edge,
    // crediting this cycle's pop.
    always_comb begin
        load_s  = {1'b0, occ_s} + {2'b00, inflight_r};
        rdreq_s = 1'b0;
        if (rst_n && !fifo_rdempty && !flush && (load_s < (3'd2 + {2'b00, pop_s}))) begin
            rdreq_s = 1'b1;
        end else begin
            rdreq_s = 1'b0;
        end
    end

    // The FIFO answers every accepted request exactly one edge later.
    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rdreq_s;
        end
    end

    // Packet beat index; flush restarts framing after any same-cycle beat.
    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (flush) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (pop_s) begin
            idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : (idx_r + IDX_ONE);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Saturating statistics; flush deliberately leaves them untouched.
    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= {CNT_WIDTH{1'b0}};
            pkt_cnt_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            if (pop_s && (beat_cnt_r != CNT_MAX)) begin
                beat_cnt_r <= beat_cnt_r + CNT_ONE;
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            if (pop_s && last_s && (pkt_cnt_r != CNT_MAX)) begin
                pkt_cnt_r <= pkt_cnt_r + CNT_ONE;
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: a FIFO model feeds the DUT and a scoreboard of
// words read from the FIFO predicts the stream, framing and counters.
module tb_fifo_rd_streamer;

    localparam int DW = 64;
    localparam int PB = 4;
    localparam int CW = 32;

    logic          rdclk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          m_ready;
    logic          fifo_rdempty;
    logic          fifo_rdreq;
    logic          m_valid;
    logic          m_last;
    logic [DW-1:0] fifo_q = '0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] pkt_cnt;

    logic          rst1_n;
    logic          flush1;
    logic          rdy1;
    logic          empty1 = 1'b0;
    logic          rdreq1;
    logic          valid1;
    logic          last1;
    logic [DW-1:0] q1 = '0;
    logic [DW-1:0] data1;
    logic [3:0]    beat_cnt1;
    logic [3:0]    pkt_cnt1;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fmem [0:1023];
    int wp = 0;
    int rp = 0;
    logic [DW-1:0] exp_q [$];

    assign fifo_rdempty = (wp == rp);

    always #5 rdclk = ~rdclk;

    fifo_rd_streamer #(.DATA_WIDTH(DW), .PKT_BEATS(PB), .CNT_WIDTH(CW)) dut (
        .rdclk(rdclk), .rst_n(rst_n), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty),
        .fifo_rdreq(fifo_rdreq), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .flush(flush), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt)
    );

    fifo_rd_streamer #(.DATA_WIDTH(DW), .PKT_BEATS(1), .CNT_WIDTH(4)) dut1 (
        .rdclk(rdclk), .rst_n(rst1_n), .fifo_q(q1), .fifo_rdempty(empty1),
        .fifo_rdreq(rdreq1), .m_data(data1), .m_valid(valid1), .m_last(last1),
        .m_ready(rdy1), .flush(flush1), .beat_cnt(beat_cnt1), .pkt_cnt(pkt_cnt1)
    );

    stream_skid2_chk u_chk (
        .clk(rdclk), .rst_n(rst_n), .push(dut.u_skid.push), .pop(dut.u_skid.pop),
        .head_valid(dut.m_valid), .occ(dut.u_skid.occ)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge rdclk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fmem[wp % 1024] = w;
        wp = wp + 1;
    endtask

    // FIFO model: registered read, no reset; every word read is expected downstream.
    task automatic fifo_model();
        forever begin
            @(posedge rdclk);
            if (fifo_rdreq && (wp != rp)) begin
                fifo_q <= fmem[rp % 1024];
                exp_q.push_back(fmem[rp % 1024]);
                rp <= rp + 1;
            end
            if (rdreq1) begin
                q1 <= q1 + 64'd1;
            end
        end
    endtask

    // Scoreboard: words leave in FIFO order, framing counts beats since the
    // last flush/reset, counters count handshakes since reset.
    task automatic monitor();
        int pos = 0;
        int hs = 0;
        int pk = 0;
        logic prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        forever begin
            @(negedge rdclk);
            if (!rst_n) begin
                exp_q.delete();
                pos = 0; hs = 0; pk = 0;
                prev_stall = 1'b0;
            end else begin
                chk("rdreq_while_empty", fifo_rdreq && fifo_rdempty, 1'b0);
                chk("beat_cnt", beat_cnt, 32'(hs));
                chk("pkt_cnt", pkt_cnt, 32'(pk));
                chk("m_last", m_last, m_valid && (pos == PB - 1));
                if (prev_stall) begin
                    chk("stall_valid", m_valid, 1'b1);
                    chk("stall_data", m_data, prev_data);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", m_data, {DW{1'b1}} ^ m_data);
                    end else begin
                        chk("beat_data", m_data, exp_q.pop_front());
                    end
                    if (pos == PB - 1) pk++;
                    pos = (pos + 1) % PB;
                    hs++;
                end
                prev_stall = m_valid && !m_ready && !flush;
                prev_data  = m_data;
                if (flush) begin
                    exp_q.delete();
                    pos = 0;
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        m_ready = 1'b1;
        while ((wp != rp) && (n < 200)) begin
            step();
            n++;
        end
        chk("drain_timeout", (n < 200), 1'b1);
        repeat (4) step();
        chk("drain_scoreboard_empty", exp_q.size(), 0);
        chk("drain_valid_low", m_valid, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int vcnt;
        int hs1;
        rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
        rst1_n = 1'b0; flush1 = 1'b0; rdy1 = 1'b0;
        fork
            fifo_model();
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) step();
        chk("rst_rdreq", fifo_rdreq, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_beat_cnt", beat_cnt, 32'd0);
        chk("rst_pkt_cnt", pkt_cnt, 32'd0);

        // Back-to-back stream of 0x10..0x17.
        for (int i = 0; i < 8; i++) push_word(64'h10 + 64'(i));
        m_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge rdclk);
            chk("b2b_rdreq", fifo_rdreq, (i < 8));
            chk("b2b_valid", m_valid, (i >= 2));
            if (i >= 2) chk("b2b_data", m_data, 64'h10 + 64'(i - 2));
            if (i >= 2) chk("b2b_last", m_last, (i == 5) || (i == 9));
        end
        step();
        chk("b2b_beat_cnt", beat_cnt, 32'd8);
        chk("b2b_pkt_cnt", pkt_cnt, 32'd2);
        drain();

        // Backpressure with m_ready pattern 1,0,0,1,0,0,...
        do_reset();
        for (int i = 0; i < 8; i++) push_word(64'h20 + 64'(i));
        n = 0;
        while ((beat_cnt != 32'd8) && (n < 80)) begin
            m_ready = ((n % 3) == 0);
            step();
            n++;
        end
        chk("bp_beat_cnt", beat_cnt, 32'd8);
        chk("bp_pkt_cnt", pkt_cnt, 32'd2);
        drain();

        // Trickle: one word every 3 cycles.
        do_reset();
        m_ready = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 28; i++) begin
            if (((i % 3) == 0) && (i < 24)) push_word(64'h30 + 64'(i / 3));
            @(negedge rdclk);
            if (m_valid) vcnt++;
            step();
        end
        chk("trickle_valid_cycles", vcnt, 8);
        chk("trickle_beat_cnt", beat_cnt, 32'd8);
        drain();

        // Flush mid-packet with two words buffered.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(64'h40 + 64'(i));
        repeat (5) step();
        m_ready = 1'b1;
        step();
        step();
        m_ready = 1'b0;
        step();
        chk("flush_pre_beat_cnt", beat_cnt, 32'd2);
        chk("flush_pre_occ", dut.u_skid.occ, 2'd2);
        flush = 1'b1;
        @(negedge rdclk);
        chk("flush_rdreq", fifo_rdreq, 1'b0);
        step();
        flush = 1'b0;
        @(negedge rdclk);
        chk("flush_valid", m_valid, 1'b0);
        chk("flush_beat_cnt", beat_cnt, 32'd2);
        m_ready = 1'b1;
        drain();
        chk("flush_post_beat_cnt", beat_cnt, 32'd6);
        chk("flush_post_pkt_cnt", pkt_cnt, 32'd1);

        // Asynchronous reset pulse mid-stream.
        for (int i = 0; i < 8; i++) push_word(64'h50 + 64'(i));
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", m_valid, 1'b0);
        chk("arst_last", m_last, 1'b0);
        chk("arst_data", m_data, 64'd0);
        chk("arst_rdreq", fifo_rdreq, 1'b0);
        chk("arst_beat_cnt", beat_cnt, 32'd0);
        step();
        rst_n = 1'b1;
        n = rp;
        drain();
        chk("arst_resumed", (n < wp), 1'b1);

        // Randomized traffic with backpressure and occasional flush.
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 3) != 0) push_word({$urandom, $urandom});
            m_ready = (($urandom % 4) != 0);
            flush = (($urandom % 40) == 0);
            step();
        end
        flush = 1'b0;
        drain();

        // PKT_BEATS=1, 4-bit saturating counters.
        rst1_n = 1'b1;
        rdy1 = 1'b1;
        hs1 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge rdclk);
            chk("p1_beat_cnt", beat_cnt1, (hs1 > 15) ? 4'd15 : 4'(hs1));
            chk("p1_pkt_cnt", pkt_cnt1, (hs1 > 15) ? 4'd15 : 4'(hs1));
            if (valid1) chk("p1_last", last1, 1'b1);
            if (valid1 && rdy1) hs1++;
        end
        chk("p1_enough_beats", (hs1 >= 20), 1'b1);
        chk("p1_beat_sat", beat_cnt1, 4'd15);
        chk("p1_pkt_sat", pkt_cnt1, 4'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_streamer.md
Name: fifo_rd_streamer

Overview:
- Read-side consumer of the team's show-ahead-free dual-clock FIFO. Lives in the FIFO's read clock domain.
- Issues rdreq against rdempty and absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer.
- Presents the words as a valid/ready stream with packet framing (m_last every PKT_BEATS beats) toward the CXL/RDMA message path.

Parameters:
- DATA_WIDTH, 64, width of FIFO word and stream data.
- PKT_BEATS, 4, beats per packet; m_last is asserted on beat PKT_BEATS-1. Legal range is 1..256.
- CNT_WIDTH, 32, width of the saturating beat statistics counter.

Ports:
- rdclk  in  1  single clock, the same clock as the FIFO's rdclk.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_q  in  DATA_WIDTH  FIFO q, valid the cycle after an accepted rdreq.
- fifo_rdempty  in  1  FIFO empty flag.
- fifo_rdreq  out  1  read request to the FIFO.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_last  out  1  last beat of packet.
- m_ready  in  1  downstream ready.
- flush  in  1  synchronous: drop skid contents and restart framing.
- beat_cnt  out  CNT_WIDTH  accepted beats since reset, saturating.
- pkt_cnt  out  CNT_WIDTH  completed packets since reset, saturating.

Behaviour:
- Reset: rst_n low asynchronously clears the following:
  - fifo_rdreq=0, m_valid=0, m_last=0, m_data=0.
  - skid occupancy=0, inflight=0, beat index=0, beat_cnt=0, pkt_cnt=0.
- Reset mid-operation: a word read by the FIFO but not yet captured is lost; this is accepted and documented. The FIFO itself has no reset.
- Read issue:
  - fifo_rdreq = !fifo_rdempty && !flush && (occ + inflight + push_pending_pop_adjust) < 2.
  - Combinational form: rdreq may assert only when a slot is guaranteed free one cycle later, counting the current-cycle pop (m_valid && m_ready).
  - Never assert rdreq while rdempty=1.
- inflight is a 1-bit register, set to fifo_rdreq each cycle. When inflight=1, fifo_q is captured into the skid tail on that edge.
  - Capture latency: rdreq at edge N, q valid after N, written into skid at edge N+1, m_valid high after N+1.
  - Throughput is 1 beat/cycle when the FIFO is non-empty and m_ready=1.
- Skid buffer: 2 entries, head drives m_data/m_valid.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - Overflow is impossible by construction; assert this in simulation.
- Stream rules:
  - Once m_valid=1, m_data and m_last hold until m_ready=1.
  - m_valid never drops without a handshake, except on flush.
- Framing:
  - beat index is ceil(log2(PKT_BEATS)) bits, wide enough for PKT_BEATS=1.
  - m_last = (index == PKT_BEATS-1) && m_valid.
  - On handshake, index increments, wrapping to 0 after the last beat.
  - PKT_BEATS=1 gives m_last on every beat.
- Counters: beat_cnt increments on each handshake; pkt_cnt increments on each handshake with m_last. Both saturate at all-ones and never wrap.
- Flush:
  - Occupancy and beat index clear next edge; m_valid=0 next cycle.
  - A word arriving from an inflight read on the flush edge is discarded.
  - fifo_rdreq is 0 while flush=1.
  - Counters are not cleared.
- flush together with a handshake: the beat counts in beat_cnt/pkt_cnt, then the state clears.

Decomposition:
- Package fifo_stream_pkg holds:
  - SKID_DEPTH=2 constant.
  - Function clog2_min1 for sizing the index.
  - Typedef stream_beat_t {data, last} shared with the future upstream FIFO writer.
- One sub-module: stream_skid2 (2-entry valid/ready skid with push/pop/clear). The top holds read issue, inflight, framing and counters.

Test Plan:
- FIFO preloaded with 8 words 0x10..0x17, m_ready=1:
  - rdreq on consecutive cycles; first m_valid 2 cycles after the first rdreq.
  - Beats 0x10..0x17 arrive back-to-back; m_last on 0x13 and 0x17; pkt_cnt=2, beat_cnt=8.
- Backpressure: 8 words, m_ready toggles 1,0,0,1,... → all 8 words arrive in order, none dropped or duplicated, m_data stable while stalled, occupancy never exceeds 2.
- Empty boundary: FIFO fed 1 word every 3 cycles → rdreq never high with rdempty=1, each word appears once, m_valid gaps between words.
- Flush mid-packet after 2 of 4 beats, with 2 words buffered:
  - Buffered words are dropped and m_valid=0 next cycle.
  - The next beat carries index 0; m_last appears 4 beats later.
  - beat_cnt keeps its value of 2.
- Async reset pulse mid-stream: all outputs are 0 immediately while rst_n is low. After release, streaming resumes from the FIFO's current head; at most 1 word is lost.
- PKT_BEATS=1, CNT_WIDTH=4, 20 beats → m_last on every beat; beat_cnt and pkt_cnt saturate at 15.
